// File: rtl/pulse_bpm_if.sv
// Control and result bundle of the heartbeat counter: enable/clear/sensor in,
// beat LED pulse and BCD snapshot out.
interface pulse_bpm_if;
   logic       en;
   logic       clr;
   logic       sensor_in;
   logic       beat;
   logic       iden;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] hundreds;
   logic       ovf;

   modport master (
      output en, clr, sensor_in,
      input  beat, iden, ones, tens, hundreds, ovf
   );

   modport slave (
      input  en, clr, sensor_in,
      output beat, iden, ones, tens, hundreds, ovf
   );
endinterface

// File: rtl/pulse_bpm_counter.sv
// Heartbeat counter: synchronises the sensor pulse, applies a refractory lockout,
// counts beats in BCD per window and strobes a 3-digit snapshot at each window end.
module pulse_bpm_counter #(
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned WINDOW_S       = 60,
   parameter int unsigned LOCKOUT_CYCLES = 25_000_000
) (
   input logic        clk,
   input logic        rst,
   pulse_bpm_if.slave bus
);

   localparam int unsigned PRE_W  = (CLK_HZ > 1)         ? $clog2(CLK_HZ)         : 1;
   localparam int unsigned SEC_W  = (WINDOW_S > 1)       ? $clog2(WINDOW_S)       : 1;
   localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned NDIG   = 3;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
   localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(WINDOW_S - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
   localparam logic [DIG_W-1:0]  NINE      = DIG_W'(9);

   typedef enum logic {
      ARMED   = 1'b0,
      LOCKOUT = 1'b1
   } state_e;

   // Sensor conditioning
   logic sync1_q, sync2_q, prev_q;
   logic rise_c;

   // Beat FSM
   state_e            state_q, state_d;
   logic [LOCK_W-1:0] lock_q, lock_d;
   logic              accept_c;

   // Window timing
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             win_end_c;
   logic             snap_c;

   // Accumulator and snapshot
   logic [NDIG-1:0][DIG_W-1:0] acc_q, acc_d, acc_inc_c;
   logic                       sat_q, sat_d, sat_inc_c;
   logic                       count_c;
   logic [NDIG-1:0][DIG_W-1:0] snap_q, snap_d;
   logic                       ovf_q, ovf_d;
   logic                       iden_q, iden_d;
   logic                       beat_q, beat_d;

   assign rise_c = sync2_q & ~prev_q;

   // Beat FSM: next state, lockout counter and beat acceptance
   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      accept_c = 1'b0;
      if (!bus.en) begin
         state_d = ARMED;
         lock_d  = '0;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (rise_c) begin
                  accept_c = 1'b1;
                  lock_d   = '0;
                  state_d  = LOCKOUT;
               end
            end
            LOCKOUT: begin
               if (lock_q == LOCK_LAST) begin
                  state_d = ARMED;
               end else begin
                  lock_d = lock_q + LOCK_W'(1);
               end
            end
            default: state_d = ARMED;
         endcase
      end
      if (bus.clr) begin
         state_d = ARMED;
      end
   end

   // Prescaler and second counter; window ends on the last tick of the last second
   always_comb begin
      pre_d     = pre_q;
      sec_d     = sec_q;
      win_end_c = bus.en && (pre_q == PRE_LAST) && (sec_q == SEC_LAST);
      if (bus.clr) begin
         pre_d = '0;
         sec_d = '0;
      end else if (bus.en) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + SEC_W'(1);
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // BCD ripple increment with saturation at 999; a beat coincident with clr is not counted
   always_comb begin
      acc_inc_c = acc_q;
      sat_inc_c = sat_q;
      count_c   = accept_c & ~bus.clr;
      if (count_c) begin
         if ((acc_q[0] == NINE) && (acc_q[1] == NINE) && (acc_q[2] == NINE)) begin
            sat_inc_c = 1'b1;
         end else if (acc_q[0] != NINE) begin
            acc_inc_c[0] = acc_q[0] + DIG_W'(1);
         end else if (acc_q[1] != NINE) begin
            acc_inc_c[0] = '0;
            acc_inc_c[1] = acc_q[1] + DIG_W'(1);
         end else begin
            acc_inc_c[0] = '0;
            acc_inc_c[1] = '0;
            acc_inc_c[2] = acc_q[2] + DIG_W'(1);
         end
      end
   end

   // Snapshot includes a beat accepted on the window-end cycle; clr suppresses it
   always_comb begin
      snap_c = win_end_c & ~bus.clr;
      snap_d = snap_q;
      ovf_d  = ovf_q;
      iden_d = snap_c;
      beat_d = accept_c;
      acc_d  = acc_inc_c;
      sat_d  = sat_inc_c;
      if (snap_c) begin
         snap_d = acc_inc_c;
         ovf_d  = sat_inc_c;
      end
      if (bus.clr || win_end_c) begin
         acc_d = '0;
         sat_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         state_q <= ARMED;
         lock_q  <= '0;
         pre_q   <= '0;
         sec_q   <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         snap_q  <= '0;
         ovf_q   <= 1'b0;
         iden_q  <= 1'b0;
         beat_q  <= 1'b0;
      end else begin
         sync1_q <= bus.sensor_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         lock_q  <= lock_d;
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         snap_q  <= snap_d;
         ovf_q   <= ovf_d;
         iden_q  <= iden_d;
         beat_q  <= beat_d;
      end
   end

   assign bus.beat     = beat_q;
   assign bus.iden     = iden_q;
   assign bus.ones     = snap_q[0];
   assign bus.tens     = snap_q[1];
   assign bus.hundreds = snap_q[2];
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_bpm_counter.sv
// Bench for pulse_bpm_counter: directed table, window corner sequences and
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_pulse_bpm_counter;

   localparam int unsigned CLK_HZ   = 100;
   localparam int unsigned WINDOW_S = 50;
   localparam int unsigned LOCK     = 3;
   localparam int          W        = CLK_HZ * WINDOW_S;
   localparam int          NTBL     = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pulse_bpm_if bus_if ();

   pulse_bpm_counter #(
      .CLK_HZ         (CLK_HZ),
      .WINDOW_S       (WINDOW_S),
      .LOCKOUT_CYCLES (LOCK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: sensor sample history, remaining lockout edges, beat total
   bit h[3];
   int lock_rem, wcnt, beats, snap;
   bit sat, snap_ovf, m_beat, m_iden;

   bit pmask[W + 200];

   typedef struct {
      bit s;
      bit e;
      bit c;
      bit xb;
   } vec_t;
   vec_t tbl[NTBL];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      h[0] = 1'b0; h[1] = 1'b0; h[2] = 1'b0;
      lock_rem = 0; wcnt = 0; beats = 0; snap = 0;
      sat = 1'b0; snap_ovf = 1'b0; m_beat = 1'b0; m_iden = 1'b0;
   endfunction

   function automatic void model_step(input bit s, input bit e, input bit c);
      bit rise, accept, wend;
      rise   = h[1] & ~h[2];
      accept = e && rise && (lock_rem == 0);
      h[2] = h[1]; h[1] = h[0]; h[0] = s;
      m_beat = accept;
      if (!e || c)          lock_rem = 0;
      else if (accept)      lock_rem = LOCK;
      else if (lock_rem > 0) lock_rem--;
      wend = e && (wcnt == W - 1);
      if (c)      wcnt = 0;
      else if (e) wcnt = wend ? 0 : wcnt + 1;
      if (accept && !c) begin
         if (beats == 999) sat = 1'b1;
         else              beats++;
      end
      m_iden = wend && !c;
      if (m_iden) begin
         snap = beats; snap_ovf = sat;
         beats = 0; sat = 1'b0;
      end
      if (c) begin
         beats = 0; sat = 1'b0;
      end
   endfunction

   task automatic check_all();
      chk("beat", bus_if.beat, m_beat);
      chk("iden", bus_if.iden, m_iden);
      chk("ones", bus_if.ones, snap % 10);
      chk("tens", bus_if.tens, (snap / 10) % 10);
      chk("hundreds", bus_if.hundreds, snap / 100);
      chk("ovf", bus_if.ovf, snap_ovf);
   endtask

   task automatic tick(input bit s, input bit e, input bit c);
      bus_if.sensor_in = s;
      bus_if.en        = e;
      bus_if.clr       = c;
      @(posedge clk);
      model_step(s, e, c);
      #1;
      check_all();
   endtask

   // One window-length run driven from pmask; reports first iden tick and captured outputs
   task automatic run_win(input int len, input int lo_from, input int lo_to, input int clr_at,
                          output int first_iden, output logic b_end,
                          output logic [3:0] o, output logic [3:0] t, output logic [3:0] hu,
                          output logic ov);
      first_iden = 0; b_end = 1'b0; o = '0; t = '0; hu = '0; ov = 1'b0;
      for (int k = 1; k <= len; k++) begin
         tick(pmask[k], !(k >= lo_from && k <= lo_to), k == clr_at);
         if (bus_if.iden === 1'b1 && first_iden == 0) begin
            first_iden = k;
            o = bus_if.ones; t = bus_if.tens; hu = bus_if.hundreds; ov = bus_if.ovf;
         end
         if (k == len) b_end = bus_if.beat;
      end
   endtask

   task automatic clear_mask();
      for (int i = 0; i < W + 200; i++) pmask[i] = 1'b0;
   endtask

   initial begin
      int fi;
      logic be, ov;
      logic [3:0] o, t, hu;
      int dens;

      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1};

      bus_if.sensor_in = 1'b0;
      bus_if.en        = 1'b0;
      bus_if.clr       = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // Directed table: lockout, en override and clr-with-beat
      for (int i = 0; i < NTBL; i++) begin
         tick(tbl[i].s, tbl[i].e, tbl[i].c);
         chk("tbl_beat", bus_if.beat, tbl[i].xb);
         chk("tbl_iden", bus_if.iden, 0);
      end

      // Beat accepted on the window-end cycle is included in the snapshot
      clear_mask(); pmask[10] = 1'b1; pmask[W - 2] = 1'b1;
      run_win(W, W + 500, W + 500, -1, fi, be, o, t, hu, ov);
      chk("endbeat_iden_pos", fi, W);
      chk("endbeat_beat", be, 1);
      chk("endbeat_ones", o, 2);
      chk("endbeat_tens", t, 0);
      chk("endbeat_hund", hu, 0);
      chk("endbeat_ovf", ov, 0);

      // Next window restarts from zero
      clear_mask(); pmask[100] = 1'b1; pmask[200] = 1'b1; pmask[300] = 1'b1;
      run_win(W, W + 500, W + 500, -1, fi, be, o, t, hu, ov);
      chk("next_iden_pos", fi, W);
      chk("next_ones", o, 3);

      // clr on the window-end cycle: no snapshot, digits keep prior value
      clear_mask(); pmask[50] = 1'b1;
      run_win(W, W + 500, W + 500, W, fi, be, o, t, hu, ov);
      chk("clrend_no_iden", fi, 0);
      chk("clrend_ones_kept", bus_if.ones, 3);

      // Saturation then recovery
      clear_mask();
      for (int k = 1; k <= W - 10; k++) pmask[k] = (k % 4 == 1);
      run_win(W, W + 500, W + 500, -1, fi, be, o, t, hu, ov);
      chk("sat_iden_pos", fi, W);
      chk("sat_ones", o, 9);
      chk("sat_tens", t, 9);
      chk("sat_hund", hu, 9);
      chk("sat_ovf", ov, 1);
      clear_mask(); pmask[10] = 1'b1; pmask[20] = 1'b1; pmask[30] = 1'b1;
      run_win(W, W + 500, W + 500, -1, fi, be, o, t, hu, ov);
      chk("unsat_ones", o, 3);
      chk("unsat_hund", hu, 0);
      chk("unsat_ovf", ov, 0);

      // en low for 100 cycles delays the window and blocks beats
      clear_mask(); pmask[500] = 1'b1; pmask[1050] = 1'b1;
      run_win(W + 100, 1001, 1100, -1, fi, be, o, t, hu, ov);
      chk("en_iden_pos", fi, W + 100);
      chk("en_ones", o, 1);

      // Randomized traffic with varying density, sporadic en drops and clr
      dens = 4;
      for (int k = 0; k < 3 * W; k++) begin
         if (k % 500 == 0) dens = int'($urandom_range(2, 12));
         tick($urandom_range(0, dens - 1) == 0,
              $urandom_range(0, 199) != 0,
              $urandom_range(0, 3999) == 0);
      end

      // Asynchronous reset mid-cycle with 37 beats accumulated
      tick(1'b0, 1'b1, 1'b1);
      clear_mask();
      for (int i = 1; i <= 37; i++) pmask[6 * i] = 1'b1;
      run_win(240, W + 500, W + 500, -1, fi, be, o, t, hu, ov);
      chk("pre_reset_beats", beats, 37);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_beat", bus_if.beat, 0);
      chk("rst_iden", bus_if.iden, 0);
      chk("rst_ones", bus_if.ones, 0);
      chk("rst_tens", bus_if.tens, 0);
      chk("rst_hund", bus_if.hundreds, 0);
      chk("rst_ovf", bus_if.ovf, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_mask();
      run_win(W, W + 500, W + 500, -1, fi, be, o, t, hu, ov);
      chk("post_rst_iden_pos", fi, W);
      chk("post_rst_ones", o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
